// File: rtl/spi_master4nano_if.sv
// spi_master4nano_if -- host command bundle for the spi_master4nano SPI master.
//
// Signals:
//   start  host -> master  command request, honoured only while busy=0
//   op     host -> master  0=write code, 1=read code, 2=write data, 3=read data
//   addr   host -> master  target address, sent verbatim
//   wdata  host -> master  write data (code writes use wdata[7:0])
//   busy   master -> host  frame in progress
//   done   master -> host  one-cycle completion pulse
//   rdata  master -> host  read result
//
// Modports: master = host/command issuer, slave = the SPI master block.
interface spi_master4nano_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;

    modport master (output start, op, addr, wdata, input busy, done, rdata);
    modport slave  (input start, op, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master4nano.sv
// spi_master4nano -- host-side SPI master (mode 0) for the Nano slave
// programming port. Each accepted command becomes one 40-bit frame, MSB
// first: opcode byte, addr[15:0], 16-bit data field.
//
// Ports:
//   CLK       system clock
//   RST       synchronous reset, active-high (aborts any frame, no done)
//   host      command bundle (spi_master4nano_if.slave)
//   SPI_CS    chip select, active-low
//   SPI_SCK   serial clock, idles low
//   SPI_MOSI  master out
//   SPI_MISO  master in
//
// Parameters:
//   HALF_DIV  CLK cycles per SCK half-period (2..255)
//   GAP_CYC   CLK cycles SPI_CS stays high between frames (1..255)
//
// Optional feature macro: SPI_MISO_SYNC_EN
//   Defined   : MISO goes through a 2-flop synchronizer and is sampled two
//               CLK cycles after the SCK rising edge (HALF_DIV >= 3).
//   Undefined : MISO is sampled directly on the SCK-raising CLK edge.
module spi_master4nano #(
    parameter int HALF_DIV = 4,
    parameter int GAP_CYC  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    spi_master4nano_if.slave        host,
    output logic                    SPI_CS,
    output logic                    SPI_SCK,
    output logic                    SPI_MOSI,
    input  logic                    SPI_MISO
);

    localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [5:0] BIT_LAST  = 6'd39;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Opcode is op+1; code writes carry only the low byte, reads send zeros.
    function automatic logic [39:0] build_frame(input logic [1:0]  op,
                                                input logic [15:0] addr,
                                                input logic [15:0] wdata);
        logic [7:0]  opcode;
        logic [15:0] data;
        opcode = {6'b000000, op} + 8'd1;
        case (op)
            2'd0:    data = {8'h00, wdata[7:0]};
            2'd2:    data = wdata;
            default: data = 16'h0000;
        endcase
        return {opcode, addr, data};
    endfunction

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic [5:0]  bit_r, bit_nxt_s;
    logic [39:0] tx_r, tx_nxt_s;
    logic [15:0] rx_r, rx_nxt_s;
    logic [15:0] rdata_r, rdata_nxt_s;
    logic [1:0]  op_r, op_nxt_s;
    logic        cs_r, cs_nxt_s;
    logic        sck_r, sck_nxt_s;
    logic        mosi_r, mosi_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;

    logic        accept_s;
    logic        half_end_s;
    logic        gap_end_s;
    logic [39:0] frame_s;

    // A start coinciding with the done pulse is dropped on purpose.
    assign accept_s   = (state_r == ST_IDLE) && host.start && !done_r;
    assign half_end_s = (cnt_r == HALF_LAST);
    assign gap_end_s  = (cnt_r == GAP_LAST);
    assign frame_s    = build_frame(host.op, host.addr, host.wdata);

`ifdef SPI_MISO_SYNC_EN
    logic miso_meta_r;
    logic miso_sync_r;

    if (HALF_DIV < 3) begin : g_half_div_chk
        $error("spi_master4nano: SPI_MISO_SYNC_EN needs HALF_DIV >= 3");
    end

    // Two-flop synchronizer for the asynchronous MISO pin
    always_ff @(posedge CLK) begin
        if (RST) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= SPI_MISO;
            miso_sync_r <= miso_meta_r;
        end
    end
`endif

    // State register and all registered outputs/datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            bit_r   <= 6'd0;
            tx_r    <= 40'd0;
            rx_r    <= 16'h0000;
            rdata_r <= 16'h0000;
            op_r    <= 2'd0;
            cs_r    <= 1'b1;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bit_r   <= bit_nxt_s;
            tx_r    <= tx_nxt_s;
            rx_r    <= rx_nxt_s;
            rdata_r <= rdata_nxt_s;
            op_r    <= op_nxt_s;
            cs_r    <= cs_nxt_s;
            sck_r   <= sck_nxt_s;
            mosi_r  <= mosi_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic: phase counter and bit counter sequencing
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bit_nxt_s   = bit_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 8'd0;
                bit_nxt_s = 6'd0;
                if (accept_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (half_end_s) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (half_end_s) begin
                    cnt_nxt_s = 8'd0;
                    // A bit ends on the falling SCK edge; counter holds at 39.
                    if (sck_r && (bit_r == BIT_LAST)) begin
                        state_nxt_s = ST_HOLD;
                    end else if (sck_r) begin
                        bit_nxt_s = bit_r + 6'd1;
                    end else begin
                        bit_nxt_s = bit_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_HOLD: begin
                if (half_end_s) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
                bit_nxt_s   = 6'd0;
            end
        endcase
    end

    // Output logic: pin levels, shift registers and result capture
    always_comb begin
        cs_nxt_s    = cs_r;
        sck_nxt_s   = sck_r;
        mosi_nxt_s  = mosi_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        tx_nxt_s    = tx_r;
        rx_nxt_s    = rx_r;
        rdata_nxt_s = rdata_r;
        op_nxt_s    = op_r;
        case (state_r)
            ST_IDLE: begin
                sck_nxt_s = 1'b0;
                if (accept_s) begin
                    cs_nxt_s   = 1'b0;
                    busy_nxt_s = 1'b1;
                    tx_nxt_s   = frame_s;
                    mosi_nxt_s = frame_s[39];
                    op_nxt_s   = host.op;
                    rx_nxt_s   = 16'h0000;
                end else begin
                    cs_nxt_s   = 1'b1;
                    busy_nxt_s = 1'b0;
                    mosi_nxt_s = 1'b0;
                end
            end
            ST_SETUP: begin
                cs_nxt_s  = 1'b0;
                sck_nxt_s = 1'b0;
            end
            ST_SHIFT: begin
                if (half_end_s) begin
                    if (!sck_r) begin
                        sck_nxt_s = 1'b1;
`ifndef SPI_MISO_SYNC_EN
                        rx_nxt_s  = {rx_r[14:0], SPI_MISO};
`endif
                    end else begin
                        sck_nxt_s = 1'b0;
                        if (bit_r == BIT_LAST) begin
                            mosi_nxt_s = 1'b0;
                        end else begin
                            tx_nxt_s   = {tx_r[38:0], 1'b0};
                            mosi_nxt_s = tx_r[38];
                        end
                    end
                end else begin
`ifdef SPI_MISO_SYNC_EN
                    // Synchronized MISO lags two cycles, so sample mid-high.
                    if (sck_r && (cnt_r == 8'd1)) begin
                        rx_nxt_s = {rx_r[14:0], miso_sync_r};
                    end else begin
                        rx_nxt_s = rx_r;
                    end
`else
                    sck_nxt_s = sck_r;
`endif
                end
            end
            ST_HOLD: begin
                mosi_nxt_s = 1'b0;
                if (half_end_s) begin
                    cs_nxt_s = 1'b1;
                end else begin
                    cs_nxt_s = 1'b0;
                end
            end
            ST_GAP: begin
                cs_nxt_s   = 1'b1;
                mosi_nxt_s = 1'b0;
                if (gap_end_s) begin
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b1;
                    // op[0] marks a read; op[1] selects data (16b) vs code (8b).
                    if (op_r[0]) begin
                        rdata_nxt_s = op_r[1] ? rx_r : {8'h00, rx_r[7:0]};
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                cs_nxt_s   = 1'b1;
                sck_nxt_s  = 1'b0;
                mosi_nxt_s = 1'b0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    assign SPI_CS     = cs_r;
    assign SPI_SCK    = sck_r;
    assign SPI_MOSI   = mosi_r;
    assign host.busy  = busy_r;
    assign host.done  = done_r;
    assign host.rdata = rdata_r;

endmodule

// File: tb/tb_spi_master4nano.sv
// tb_spi_master4nano -- directed, table-driven bench for spi_master4nano
// with a mode-0 slave model on the SPI pins.
module tb_spi_master4nano;

    localparam int HALF_DIV   = 4;
    localparam int GAP_CYC    = 8;
    localparam int EXP_CS_LOW = HALF_DIV * (2 + 80);
    localparam int EXP_LAT    = 1 + EXP_CS_LOW + GAP_CYC;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SPI_MISO = 1'b0;
    logic SPI_CS, SPI_SCK, SPI_MOSI;

    spi_master4nano_if bus();

    spi_master4nano #(.HALF_DIV(HALF_DIV), .GAP_CYC(GAP_CYC)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .host     (bus),
        .SPI_CS   (SPI_CS),
        .SPI_SCK  (SPI_SCK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [39:0] resp_r = 40'd0;
    int          miso_idx = 0;
    int          sck_cnt = 0;
    logic [39:0] mosi_cap = 40'd0;

    // Slave model: present the first bit when CS falls, advance on SCK falls.
    always @(negedge SPI_CS) begin
        miso_idx = 0;
        SPI_MISO = resp_r[39];
    end

    always @(negedge SPI_SCK) begin
        if (SPI_CS === 1'b0) begin
            miso_idx = miso_idx + 1;
            if (miso_idx < 40) SPI_MISO = resp_r[39 - miso_idx];
        end
    end

    always @(posedge SPI_SCK) begin
        mosi_cap = {mosi_cap[38:0], SPI_MOSI};
        sck_cnt  = sck_cnt + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] miso_word;
        logic [39:0] exp_mosi;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] op, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] miso_word);
        resp_r    = {24'hA5A5A5, miso_word};
        sck_cnt   = 0;
        mosi_cap  = 40'd0;
        bus.op    = op;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called one cycle after acceptance (cycle 1); returns at the done cycle.
    task automatic wait_done(input bit extra, output int lat, output int cs_low, output bit ok);
        int k;
        k = 1; lat = 0; cs_low = 0; ok = 1'b0;
        while (k <= 2000) begin
            if (SPI_CS === 1'b0) cs_low++;
            if (bus.done === 1'b1) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
            bus.start = (extra && (k == 10 || k == 200)) ? 1'b1 : 1'b0;
            tick();
            k++;
        end
        bus.start = 1'b0;
    endtask

    task automatic tail(input int n, output int dn, output int csl);
        dn = 0; csl = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done === 1'b1) dn++;
            if (SPI_CS === 1'b0) csl++;
        end
    endtask

    vec_t vecs[4];

    initial begin
        int lat, csl, dn, gap_hi, k;
        bit ok;

        vecs[0] = '{op: 2'd2, addr: 16'h0005, wdata: 16'hBEEF, miso_word: 16'h1234,
                    exp_mosi: 40'h03_0005_BEEF, exp_rdata: 16'h0000};
        vecs[1] = '{op: 2'd3, addr: 16'h0001, wdata: 16'h1111, miso_word: 16'hA55A,
                    exp_mosi: 40'h04_0001_0000, exp_rdata: 16'hA55A};
        vecs[2] = '{op: 2'd1, addr: 16'h0002, wdata: 16'h0000, miso_word: 16'hFF3C,
                    exp_mosi: 40'h02_0002_0000, exp_rdata: 16'h003C};
        vecs[3] = '{op: 2'd0, addr: 16'h0010, wdata: 16'h12C7, miso_word: 16'h0000,
                    exp_mosi: 40'h01_0010_00C7, exp_rdata: 16'h003C};

        bus.start = 1'b0; bus.op = 2'd0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
        RST = 1'b1;
        tick(); tick(); tick();
        check("rst_cs",    40'(SPI_CS),    40'd1);
        check("rst_sck",   40'(SPI_SCK),   40'd0);
        check("rst_mosi",  40'(SPI_MOSI),  40'd0);
        check("rst_busy",  40'(bus.busy),  40'd0);
        check("rst_done",  40'(bus.done),  40'd0);
        check("rst_rdata", 40'(bus.rdata), 40'd0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].miso_word);
            check($sformatf("v%0d_cs_low_at_start", i), 40'(SPI_CS), 40'd0);
            wait_done(1'b0, lat, csl, ok);
            check($sformatf("v%0d_done_seen", i), 40'(ok), 40'd1);
            check($sformatf("v%0d_latency", i), 40'(lat), 40'(EXP_LAT));
            check($sformatf("v%0d_cs_low_cycles", i), 40'(csl), 40'(EXP_CS_LOW));
            check($sformatf("v%0d_sck_pulses", i), 40'(sck_cnt), 40'd40);
            check($sformatf("v%0d_mosi_frame", i), mosi_cap, vecs[i].exp_mosi);
            check($sformatf("v%0d_rdata", i), 40'(bus.rdata), 40'(vecs[i].exp_rdata));
            check($sformatf("v%0d_busy_at_done", i), 40'(bus.busy), 40'd0);
            tail(20, dn, csl);
            check($sformatf("v%0d_tail_done", i), 40'(dn), 40'd0);
            check($sformatf("v%0d_tail_cs", i), 40'(csl), 40'd0);
        end

        // Reset in the middle of bit 20
        start_frame(2'd2, 16'hFFFF, 16'hFFFF, 16'h0000);
        k = 0;
        while (sck_cnt < 20 && k < 2000) begin
            tick();
            k++;
        end
        check("mid_reached_bit20", 40'(sck_cnt), 40'd20);
        RST = 1'b1;
        tick();
        check("mid_rst_cs",    40'(SPI_CS),    40'd1);
        check("mid_rst_sck",   40'(SPI_SCK),   40'd0);
        check("mid_rst_mosi",  40'(SPI_MOSI),  40'd0);
        check("mid_rst_busy",  40'(bus.busy),  40'd0);
        check("mid_rst_done",  40'(bus.done),  40'd0);
        check("mid_rst_rdata", 40'(bus.rdata), 40'd0);
        RST = 1'b0;
        tail(400, dn, csl);
        check("mid_rst_no_done", 40'(dn),  40'd0);
        check("mid_rst_cs_idle", 40'(csl), 40'd0);

        start_frame(2'd3, 16'h00AB, 16'h0000, 16'h0F0F);
        wait_done(1'b0, lat, csl, ok);
        check("clean_done_seen", 40'(ok), 40'd1);
        check("clean_latency",   40'(lat), 40'(EXP_LAT));
        check("clean_sck",       40'(sck_cnt), 40'd40);
        check("clean_mosi",      mosi_cap, 40'h04_00AB_0000);
        check("clean_rdata",     40'(bus.rdata), 40'h0F0F);
        tail(20, dn, csl);

        // Stray starts mid-frame, then start held across the done pulse
        start_frame(2'd2, 16'h1234, 16'h5678, 16'h0000);
        wait_done(1'b1, lat, csl, ok);
        check("b2b_done_seen", 40'(ok), 40'd1);
        check("b2b_latency",   40'(lat), 40'(EXP_LAT));
        check("b2b_sck",       40'(sck_cnt), 40'd40);
        check("b2b_mosi",      mosi_cap, 40'h03_1234_5678);
        gap_hi    = lat - csl;
        resp_r    = {24'hA5A5A5, 16'h1357};
        sck_cnt   = 0;
        mosi_cap  = 40'd0;
        bus.op    = 2'd3;
        bus.addr  = 16'h0007;
        bus.wdata = 16'h0000;
        bus.start = 1'b1;
        tick();
        check("b2b_ignore_cs",   40'(SPI_CS),   40'd1);
        check("b2b_ignore_busy", 40'(bus.busy), 40'd0);
        if (SPI_CS === 1'b1) gap_hi++;
        tick();
        bus.start = 1'b0;
        check("b2b_accept_cs",   40'(SPI_CS),   40'd0);
        check("b2b_accept_busy", 40'(bus.busy), 40'd1);
        check("b2b_gap_cycles",  40'(gap_hi),   40'(GAP_CYC + 2));
        wait_done(1'b0, lat, csl, ok);
        check("b2b2_done_seen", 40'(ok), 40'd1);
        check("b2b2_latency",   40'(lat), 40'(EXP_LAT));
        check("b2b2_sck",       40'(sck_cnt), 40'd40);
        check("b2b2_mosi",      mosi_cap, 40'h04_0007_0000);
        check("b2b2_rdata",     40'(bus.rdata), 40'h1357);
        tail(20, dn, csl);
        check("b2b2_tail_done", 40'(dn),  40'd0);
        check("b2b2_tail_cs",   40'(csl), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
